// File: rtl/prime_game_pkg.sv
// Shared definitions for the prime guessing game: controller states and
// default widths/limits used by the checker and the display side.
package prime_game_pkg;

   localparam int DEF_WIDTH = 7;
   localparam int DEF_LIVES = 3;
   localparam logic [DEF_WIDTH-1:0] SCORE_MAX = '1;

   typedef enum logic [2:0] {
      IDLE,
      REQUEST,
      WAIT,
      GUESS,
      JUDGE,
      OVER
   } state_e;

endpackage

// File: rtl/prime_guess_checker.sv
// Game controller: requests a prime from the LFSR generator, waits out its
// latency, judges one player guess per round and tracks score and lives.
module prime_guess_checker
   import prime_game_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int GEN_LATENCY = 4,
   parameter int TIMEOUT     = 1000,
   parameter int LIVES       = DEF_LIVES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] guess,
   input  logic             guess_valid,
   input  logic [WIDTH-1:0] prime_in,
   output logic             gen_enable,
   output logic [WIDTH-1:0] gen_score,
   output logic             guess_ready,
   output logic [WIDTH-1:0] score,
   output logic [1:0]       lives,
   output logic             correct,
   output logic             wrong,
   output logic             game_over,
   output logic             busy
);

   // One down-counter serves both the generator latency and the guess timeout.
   localparam int CNT_MAX = (GEN_LATENCY > TIMEOUT) ? GEN_LATENCY : TIMEOUT;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [WIDTH-1:0] SCORE_TOP = '1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   prime_q, prime_d;
   logic [WIDTH-1:0]   score_q, score_d;
   logic [1:0]         lives_q, lives_d;
   logic               correct_d, wrong_d;
   logic               gen_enable_q, guess_ready_q, correct_q, wrong_q;
   logic               game_over_q, busy_q;
   logic [WIDTH-1:0]   gen_score_q;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path infers a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      prime_d   = prime_q;
      score_d   = score_q;
      lives_d   = lives_q;
      correct_d = 1'b0;
      wrong_d   = 1'b0;
      unique case (state_q)
         IDLE, OVER: begin
            if (start) begin
               state_d = REQUEST;
               score_d = '0;
               lives_d = 2'(LIVES);
            end
         end
         REQUEST: begin
            cnt_d   = CNT_W'(GEN_LATENCY - 1);
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == '0) begin
               prime_d = prime_in;
               cnt_d   = CNT_W'(TIMEOUT - 1);
               state_d = GUESS;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GUESS: begin
            // A guess presented on the expiry cycle still gets judged on its merits.
            if (guess_valid || cnt_q == '0) begin
               state_d = JUDGE;
               if (guess_valid && guess == prime_q) begin
                  correct_d = 1'b1;
                  if (score_q != SCORE_TOP) score_d = score_q + 1'b1;
               end else begin
                  wrong_d = 1'b1;
                  if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         JUDGE:   state_d = (lives_q == 2'd0) ? OVER : REQUEST;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so each one comes straight off a flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         prime_q       <= '0;
         score_q       <= '0;
         lives_q       <= 2'(LIVES);
         gen_enable_q  <= 1'b0;
         gen_score_q   <= '0;
         guess_ready_q <= 1'b0;
         correct_q     <= 1'b0;
         wrong_q       <= 1'b0;
         game_over_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         prime_q       <= prime_d;
         score_q       <= score_d;
         lives_q       <= lives_d;
         gen_enable_q  <= (state_d == REQUEST);
         gen_score_q   <= (state_d == REQUEST) ? score_d : '0;
         guess_ready_q <= (state_d == GUESS);
         correct_q     <= correct_d;
         wrong_q       <= wrong_d;
         game_over_q   <= (state_d == OVER);
         busy_q        <= (state_d != IDLE) && (state_d != OVER);
      end
   end

   assign gen_enable  = gen_enable_q;
   assign gen_score   = gen_score_q;
   assign guess_ready = guess_ready_q;
   assign score       = score_q;
   assign lives       = lives_q;
   assign correct     = correct_q;
   assign wrong       = wrong_q;
   assign game_over   = game_over_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_prime_guess_checker.sv
// Bench for prime_guess_checker: a round-timeline model predicts every output
// each cycle; directed scenarios add hand-computed literal expectations.
module tb_prime_guess_checker;

   localparam int W  = 7;
   localparam int L  = 4;
   localparam int T  = 16;
   localparam int LV = 3;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] guess;
   logic         guess_valid;
   logic [W-1:0] prime_in;
   logic         gen_enable;
   logic [W-1:0] gen_score;
   logic         guess_ready;
   logic [W-1:0] score;
   logic [1:0]   lives;
   logic         correct;
   logic         wrong;
   logic         game_over;
   logic         busy;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 0;

   prime_guess_checker #(
      .WIDTH(W), .GEN_LATENCY(L), .TIMEOUT(T), .LIVES(LV)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .guess(guess),
      .guess_valid(guess_valid), .prime_in(prime_in),
      .gen_enable(gen_enable), .gen_score(gen_score),
      .guess_ready(guess_ready), .score(score), .lives(lives),
      .correct(correct), .wrong(wrong), .game_over(game_over), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Round timeline model: a round is described by the cycle of its generator
   // request and the cycle of its judgement; all outputs follow from offsets.
   int           cyc      = 0;
   int           req_at   = -1;
   int           judge_at = -1;
   bit           active   = 0;
   bit           over_m   = 0;
   bit           ok_m     = 0;
   logic [W-1:0] score_m  = '0;
   logic [W-1:0] prime_m  = '0;
   logic [1:0]   lives_m  = 2'(LV);

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         active = 0; over_m = 0; ok_m = 0; score_m = '0; prime_m = '0;
         lives_m = 2'(LV); req_at = -1; judge_at = -1;
      end else begin
         int n;
         int gs;
         n  = cyc;
         gs = req_at + 1 + L;
         if (!active) begin
            if (start) begin
               active = 1; over_m = 0; score_m = '0; lives_m = 2'(LV);
               req_at = n + 1; judge_at = -1;
            end
         end else if (judge_at == n) begin
            if (lives_m == 2'd0) begin
               active = 0; over_m = 1;
            end else begin
               req_at = n + 1; judge_at = -1;
            end
         end else begin
            if (n == gs - 1) prime_m = prime_in;
            if (n >= gs && (guess_valid || n == gs + T - 1)) begin
               judge_at = n + 1;
               ok_m = guess_valid && (guess == prime_m);
               if (ok_m) begin
                  if (score_m != 7'd127) score_m = score_m + 7'd1;
               end else if (lives_m != 2'd0) begin
                  lives_m = lives_m - 2'd1;
               end
            end
         end
         cyc++;
      end
   end

   logic exp_ge, exp_ready;
   assign exp_ge    = active && (cyc == req_at);
   assign exp_ready = active && (judge_at < 0) && (cyc >= req_at + 1 + L);

   initial forever begin
      @(negedge clk);
      if (cmp_en && rst)
         check("cycle_outputs",
               32'({gen_enable, gen_score, guess_ready, score, lives, correct, wrong, game_over, busy}),
               32'({exp_ge, exp_ge ? score_m : 7'd0, exp_ready, score_m, lives_m,
                    active && judge_at == cyc && ok_m, active && judge_at == cyc && !ok_m,
                    over_m, active}));
   end

   task automatic wait_ready(input int max_cyc);
      int k;
      k = 0;
      while (guess_ready !== 1'b1 && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      check("wait_guess_ready", 32'(guess_ready), 32'd1);
   endtask

   initial begin
      int ge_cnt;
      rst = 1'b1; start = 1'b0; guess = '0; guess_valid = 1'b0; prime_in = '0;
      #3 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_score", 32'(score), 32'd0);
      check("rst_lives", 32'(lives), 32'd3);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_gen_enable", 32'(gen_enable), 32'd0);
      check("rst_guess_ready", 32'(guess_ready), 32'd0);
      check("rst_game_over", 32'(game_over), 32'd0);
      rst = 1'b1;
      cmp_en = 1'b1;
      @(negedge clk);
      check("idle_no_gen", 32'(gen_enable), 32'd0);

      // Correct round, prime 13.
      prime_in = 7'd13; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("req_gen_enable", 32'(gen_enable), 32'd1);
      check("req_gen_score", 32'(gen_score), 32'd0);
      @(negedge clk);
      check("req_single_pulse", 32'(gen_enable), 32'd0);
      repeat (3) @(negedge clk);
      check("wait_not_ready", 32'(guess_ready), 32'd0);
      @(negedge clk);
      check("latency_ready", 32'(guess_ready), 32'd1);
      guess = 7'd13; guess_valid = 1'b1;
      @(negedge clk);
      guess_valid = 1'b0;
      check("correct_pulse", 32'(correct), 32'd1);
      check("correct_score", 32'(score), 32'd1);
      check("judge_not_ready", 32'(guess_ready), 32'd0);
      @(negedge clk);
      check("next_gen_enable", 32'(gen_enable), 32'd1);
      check("next_gen_score", 32'(gen_score), 32'd1);

      // Three wrong guesses end the game.
      for (int i = 0; i < 3; i++) begin
         wait_ready(20);
         guess = 7'd12; guess_valid = 1'b1;
         @(negedge clk);
         guess_valid = 1'b0;
         check("wrong_pulse", 32'(wrong), 32'd1);
         check("wrong_lives", 32'(lives), 32'(2 - i));
      end
      @(negedge clk);
      check("over_game_over", 32'(game_over), 32'd1);
      check("over_busy", 32'(busy), 32'd0);
      check("over_score_held", 32'(score), 32'd1);
      ge_cnt = 0;
      repeat (6) begin
         @(negedge clk);
         ge_cnt += int'(gen_enable);
      end
      check("over_no_gen", 32'(ge_cnt), 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("restart_gen_enable", 32'(gen_enable), 32'd1);
      check("restart_score", 32'(score), 32'd0);
      check("restart_lives", 32'(lives), 32'd3);

      // Timeout after T guess cycles.
      wait_ready(20);
      repeat (T - 1) @(negedge clk);
      check("timeout_last_ready", 32'(guess_ready), 32'd1);
      @(negedge clk);
      check("timeout_wrong", 32'(wrong), 32'd1);
      check("timeout_correct", 32'(correct), 32'd0);
      check("timeout_lives", 32'(lives), 32'd2);
      @(negedge clk);
      check("timeout_next_gen", 32'(gen_enable), 32'd1);

      // Correct guess on the expiry cycle.
      wait_ready(20);
      repeat (T - 1) @(negedge clk);
      guess = 7'd13; guess_valid = 1'b1;
      @(negedge clk);
      guess_valid = 1'b0;
      check("race_correct", 32'(correct), 32'd1);
      check("race_wrong", 32'(wrong), 32'd0);
      check("race_score", 32'(score), 32'd1);

      // Randomized play with noise on ignored inputs.
      for (int i = 0; i < 3000; i++) begin
         prime_in = 7'($urandom);
         if (exp_ready) begin
            guess_valid = ($urandom_range(4) == 0);
            guess = ($urandom_range(3) != 0) ? prime_m : 7'($urandom);
            start = 1'($urandom_range(1));
         end else begin
            guess_valid = 1'($urandom_range(1));
            guess = 7'($urandom);
            start = ($urandom_range(3) == 0);
         end
         @(negedge clk);
      end

      // Asynchronous reset in the middle of GUESS.
      guess_valid = 1'b0; start = 1'b1;
      wait_ready(60);
      start = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("midrst_ready", 32'(guess_ready), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_score", 32'(score), 32'd0);
      check("midrst_lives", 32'(lives), 32'd3);
      @(negedge clk);
      rst = 1'b1;
      ge_cnt = 0;
      repeat (6) begin
         @(negedge clk);
         ge_cnt += int'(gen_enable);
      end
      check("midrst_no_gen", 32'(ge_cnt), 32'd0);

      // Saturation: start and guess_valid held high throughout.
      start = 1'b1; guess_valid = 1'b1;
      for (int i = 0; i < 1100; i++) begin
         prime_in = 7'($urandom);
         guess = exp_ready ? prime_m : 7'($urandom);
         @(negedge clk);
      end
      check("sat_score", 32'(score), 32'd127);
      check("sat_lives", 32'(lives), 32'd3);
      check("sat_busy", 32'(busy), 32'd1);
      start = 1'b0; guess_valid = 1'b0;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prime_guess_checker.md
Name: prime_guess_checker

Overview:
- Game-side consumer for the LFSR prime generator (the counterpart of LFSR_Prime).
- Drives the generator's enable/score inputs and latches the returned prime after a fixed generator latency.
- Collects one player guess per round, judges it and keeps score and lives.
- Sits between the player input logic and the generator; the score and lives outputs feed the display.

Parameters:
WIDTH, 7, bit width of prime, guess and score (matches the generator's 7-bit bus)
GEN_LATENCY, 4, cycles from the gen_enable pulse until prime_in is stable; must be >= 1
TIMEOUT, 1000, cycles allowed in GUESS before the round counts as wrong; must be >= 1
LIVES, 3, wrong answers allowed per game; range 1..3

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  begin a new game; sampled only in IDLE or OVER
guess  input  WIDTH  player's guessed prime
guess_valid  input  1  guess is presented; accepted when guess_ready=1
prime_in  input  WIDTH  generator output (primeNumberOutput)
gen_enable  output  1  one-cycle request pulse to the generator
gen_score  output  WIDTH  score handed to the generator; valid while gen_enable=1
guess_ready  output  1  high in GUESS only
score  output  WIDTH  current score, saturating
lives  output  2  remaining lives
correct  output  1  one-cycle pulse per correct judgement
wrong  output  1  one-cycle pulse per wrong guess or timeout
game_over  output  1  high in OVER
busy  output  1  high in any state other than IDLE and OVER

Behaviour:
- Clock, reset and outputs
  - Single clock domain.
  - rst=0 asynchronously forces IDLE: score=0, lives=LIVES, every other output 0, internal counters and prime register 0. This applies in any state, including mid-round.
  - All outputs are registered.
- IDLE
  - start=1 -> REQUEST; score cleared, lives reloaded to LIVES.
- REQUEST (1 cycle)
  - gen_enable=1 and gen_score=score.
  - Latency counter loaded with GEN_LATENCY-1 -> WAIT.
  - gen_enable is never high for two consecutive cycles.
- WAIT
  - Counter decrements each cycle.
  - At 0: latch prime_in into prime_reg, load timeout counter with TIMEOUT-1 -> GUESS.
- GUESS
  - guess_ready=1.
  - guess_valid=1: latch guess -> JUDGE.
  - Otherwise the timeout counter decrements; expiry at 0 with no guess -> JUDGE with a forced mismatch.
  - guess_valid coinciding with the expiry cycle: the guess wins and is judged normally.
- JUDGE (1 cycle)
  - guess == prime_reg: correct=1; score=score+1, saturating at 2^WIDTH-1.
  - Mismatch or timeout: wrong=1; lives=lives-1.
  - Next state: lives reaching 0 -> OVER, otherwise REQUEST.
- OVER
  - game_over=1; score and lives hold.
  - start=1 -> REQUEST with score cleared and lives reloaded (same as IDLE).
- Ignored inputs
  - start in states other than IDLE/OVER.
  - guess_valid outside GUESS.
  - prime_in outside the WAIT latch cycle.
- Round latency with no stall: start edge -> REQUEST next cycle -> GEN_LATENCY cycles in WAIT -> GUESS. A guess accepted at cycle g produces correct/wrong at cycle g+1, and the next gen_enable follows at g+2.
- Width rules
  - All comparisons are unsigned and exact-width.
  - Score never wraps.
  - lives never underflows; a decrement is only possible while lives >= 1.

Decomposition:
- Shared package prime_game_pkg holds:
  - state enum {IDLE, REQUEST, WAIT, GUESS, JUDGE, OVER};
  - WIDTH default;
  - SCORE_MAX constant (2^WIDTH-1);
  - LIVES default.
- No sub-module is needed. The latency and timeout counters share one down-counter inline, since WAIT and GUESS are mutually exclusive.

Test Plan:
- Reset mid-round: drive rst=0 while in GUESS -> same cycle guess_ready=0, busy=0, score=0, lives=3; after rst=1, no gen_enable until start.
- Correct round (GEN_LATENCY=4, prime_in=13): start -> gen_enable high exactly 1 cycle with gen_score=0; guess_ready rises 4 cycles later; guess=13 -> correct pulse, score=1; next gen_enable carries gen_score=1.
- Three wrong guesses (prime 13, guess 12) -> wrong pulses, lives 3->2->1->0, game_over=1, busy=0, no further gen_enable; start then restarts with score=0, lives=3.
- Timeout (TIMEOUT=16): no guess_valid for 16 GUESS cycles -> wrong pulse, lives 3->2, new gen_enable 2 cycles later.
- Race: correct guess_valid on the timeout expiry cycle -> correct=1, wrong=0, score incremented.
- Saturation (WIDTH=3): 9 consecutive correct rounds -> score climbs to 7 and holds at 7; start and guess_valid held high outside their states have no effect.
